// File: rtl/fifo_write_arbiter_if.sv
// Write-port bundle between the requesters/FIFO side and the round-robin write arbiter.
// master is the arbiter's view; slave is the requester/FIFO side.
interface fifo_write_arbiter_if #(
  parameter int WORD_SIZE = 8,
  parameter int ID_SIZE   = 2
);
  localparam int NUM_REQ = 1 << ID_SIZE;

  logic [NUM_REQ-1:0]           req;
  logic [NUM_REQ*WORD_SIZE-1:0] req_word;
  logic                         full;
  logic [NUM_REQ-1:0]           ack;
  logic                         wen;
  logic [WORD_SIZE-1:0]         w_word;
  logic [ID_SIZE-1:0]           owner;
  logic                         busy;

  modport master (
    input  req, req_word, full,
    output ack, wen, w_word, owner, busy
  );

  modport slave (
    output req, req_word, full,
    input  ack, wen, w_word, owner, busy
  );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin owner of the async FIFO write port: one requester holds the port for
// up to MAX_BURST accepted words, never writes while full, and idles one cycle between grants.
module fifo_write_arbiter #(
  parameter int WORD_SIZE = 8,
  parameter int ID_SIZE   = 2,
  parameter int MAX_BURST = 4
) (
  input logic                  clk,
  input logic                  rst,
  fifo_write_arbiter_if.master bus
);
  localparam int         NUM_REQ    = 1 << ID_SIZE;
  localparam logic [7:0] BURST_LAST = 8'(MAX_BURST);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             r_state;
  logic [ID_SIZE-1:0] r_owner;
  logic [ID_SIZE-1:0] r_last;
  logic [7:0]         r_bcnt;

  logic [ID_SIZE-1:0] w_sel;
  logic [ID_SIZE-1:0] w_idx;
  logic               w_found;
  logic               w_own_req;
  logic               w_wen;

  // Scan last+1 .. last+NUM_REQ; the final step wraps back onto last itself.
  always_comb begin
    w_sel   = r_last;
    w_idx   = r_last;
    w_found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = r_last + ID_SIZE'(k);
      if (!w_found && bus.req[w_idx]) begin
        w_found = 1'b1;
        w_sel   = w_idx;
      end
    end
  end

  assign w_own_req = bus.req[r_owner];
  assign w_wen     = (r_state == GRANT) && w_own_req && !bus.full;

  // Write strobe and data stay combinational so a stall on full costs no bubble.
  assign bus.wen    = w_wen;
  assign bus.ack    = w_wen ? (NUM_REQ'(1) << r_owner) : '0;
  assign bus.w_word = w_wen ? bus.req_word[r_owner*WORD_SIZE +: WORD_SIZE] : '0;
  assign bus.owner  = r_owner;
  assign bus.busy   = (r_state == GRANT);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_owner <= '0;
      r_bcnt  <= '0;
      r_last  <= '1;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_owner <= w_sel;
            r_bcnt  <= '0;
            r_state <= GRANT;
          end
        end
        GRANT: begin
          // A withdrawn request releases even during a full stall.
          if (!w_own_req) begin
            r_last  <= r_owner;
            r_state <= IDLE;
          end else if (w_wen) begin
            r_bcnt <= r_bcnt + 8'd1;
            if (r_bcnt + 8'd1 == BURST_LAST) begin
              r_last  <= r_owner;
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: requester queues feed the DUT, a scoreboard checks every
// written word, and directed scenarios check cycle-exact grant/stall/reset behaviour.
module tb_fifo_write_arbiter;
  localparam int NR       = 4;
  localparam int MB       = 4;
  localparam int WAIT_MAX = NR * (MB + 1);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_write_arbiter_if #(.WORD_SIZE(8), .ID_SIZE(2)) bus  ();
  fifo_write_arbiter_if #(.WORD_SIZE(8), .ID_SIZE(2)) bus1 ();

  fifo_write_arbiter #(.WORD_SIZE(8), .ID_SIZE(2), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  fifo_write_arbiter #(.WORD_SIZE(8), .ID_SIZE(2), .MAX_BURST(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  typedef struct packed { logic [1:0] id; logic [7:0] w; } wr_t;

  logic [7:0]   src_q [NR][$];
  wr_t          exp_q [$];
  wr_t          exp1_q[$];
  logic [NR-1:0] drop_mask;
  bit           chk_exp;
  bit           soak_en;
  int           wait_cnt [NR];
  int           errors;
  int           checks;

  logic       obs_wen, obs_busy, obs1_wen;
  logic [3:0] obs_ack, obs1_ack;
  logic [7:0] obs_word, obs1_word;
  logic [1:0] obs_owner, obs1_owner;

  task automatic drive_reqs();
    for (int i = 0; i < NR; i++) begin
      bus.req[i]             = (src_q[i].size() > 0) && !drop_mask[i];
      bus.req_word[i*8 +: 8] = (src_q[i].size() > 0) ? src_q[i][0] : 8'h00;
    end
  endtask

  // Observe the current cycle at negedge, then move to the next cycle and update requesters.
  task automatic tick();
    bit         pop_v;
    logic [1:0] id;
    wr_t        e;
    pop_v = 1'b0;
    id    = 2'd0;
    @(negedge clk);
    obs_wen  = bus.wen;  obs_ack  = bus.ack;  obs_word  = bus.w_word;
    obs_owner = bus.owner; obs_busy = bus.busy;
    obs1_wen = bus1.wen; obs1_ack = bus1.ack; obs1_word = bus1.w_word; obs1_owner = bus1.owner;
    if (bus.wen === 1'b1) begin
      id = bus.owner;
      checks++;
      if (bus.full !== 1'b0) begin
        errors++; $display("FAIL wr_while_full: full=%b during write, required 0", bus.full);
      end
      checks++;
      if (!$onehot(bus.ack) || bus.ack[id] !== 1'b1) begin
        errors++; $display("FAIL ack_onehot: ack=%b owner=%0d, required one-hot at owner", bus.ack, id);
      end
      checks++;
      if (src_q[id].size() == 0) begin
        errors++; $display("FAIL wr_data: requester %0d wrote %h, required nothing pending", id, bus.w_word);
      end else begin
        pop_v = 1'b1;
        if (bus.w_word !== src_q[id][0]) begin
          errors++; $display("FAIL wr_data: requester %0d wrote %h, required %h", id, bus.w_word, src_q[id][0]);
        end
      end
      if (chk_exp) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL sb_extra: write id=%0d word=%h, required no write", id, bus.w_word);
        end else begin
          e = exp_q.pop_front();
          if (e !== {id, bus.w_word}) begin
            errors++; $display("FAIL sb_order: got id=%0d word=%h, required id=%0d word=%h", id, bus.w_word, e.id, e.w);
          end
        end
      end
    end else begin
      checks++;
      if (bus.ack !== 4'b0000 || bus.w_word !== 8'h00) begin
        errors++; $display("FAIL idle_outputs: ack=%b w_word=%h, required 0/00", bus.ack, bus.w_word);
      end
    end
    if (soak_en) begin
      for (int i = 0; i < NR; i++) begin
        if (bus.req[i] && !bus.ack[i]) begin
          if (!bus.full) wait_cnt[i]++;
        end else begin
          wait_cnt[i] = 0;
        end
        checks++;
        if (wait_cnt[i] > WAIT_MAX) begin
          errors++; $display("FAIL fairness: requester %0d waited %0d, required <= %0d", i, wait_cnt[i], WAIT_MAX);
          wait_cnt[i] = 0;
        end
      end
    end
    @(posedge clk);
    #1;
    if (pop_v) void'(src_q[id].pop_front());
    drive_reqs();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic flush();
    for (int i = 0; i < NR; i++) src_q[i].delete();
    drop_mask = '0;
    bus.full  = 1'b0;
    drive_reqs();
    repeat (3) tick();
  endtask

  task automatic test_reset();
    do_reset();
    tick();
    checks++;
    if (obs_wen !== 1'b0 || obs_ack !== 4'b0 || obs_word !== 8'h00) begin
      errors++; $display("FAIL rst_outputs: wen=%b ack=%b w_word=%h, required 0", obs_wen, obs_ack, obs_word);
    end
    checks++;
    if (obs_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b, required 0", obs_busy); end
    checks++;
    if (obs_owner !== 2'd0) begin errors++; $display("FAIL rst_owner: got %0d, required 0", obs_owner); end
  endtask

  task automatic test_single();
    logic [8:0] ew = 9'b011011110;
    logic [8:0] eb = 9'b111011110;
    for (int i = 0; i < 6; i++) src_q[2].push_back(8'hA0 + 8'(i));
    do_reset();
    for (int i = 0; i < 6; i++) exp_q.push_back({2'd2, 8'hA0 + 8'(i)});
    chk_exp = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      checks++;
      if (obs_wen !== ew[k-1]) begin errors++; $display("FAIL single_wen c%0d: got %b, required %b", k, obs_wen, ew[k-1]); end
      checks++;
      if (obs_busy !== eb[k-1]) begin errors++; $display("FAIL single_busy c%0d: got %b, required %b", k, obs_busy, eb[k-1]); end
      checks++;
      if (obs_owner !== ((k >= 2) ? 2'd2 : 2'd0)) begin
        errors++; $display("FAIL single_owner c%0d: got %0d, required %0d", k, obs_owner, (k >= 2) ? 2 : 0);
      end
    end
    tick();
    checks++;
    if (exp_q.size() != 0 || obs_busy !== 1'b0) begin
      errors++; $display("FAIL single_done: pending=%0d busy=%b, required 0/0", exp_q.size(), obs_busy);
    end
    chk_exp = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_full_stall();
    logic [8:0] ew = 9'b011100010;
    logic [8:0] eb = 9'b011111110;
    for (int i = 0; i < 4; i++) src_q[1].push_back(8'h54 + 8'(i));
    do_reset();
    for (int i = 0; i < 4; i++) exp_q.push_back({2'd1, 8'h54 + 8'(i)});
    chk_exp = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      bus.full = (k >= 3 && k <= 5);
      tick();
      checks++;
      if (obs_wen !== ew[k-1]) begin errors++; $display("FAIL stall_wen c%0d: got %b, required %b", k, obs_wen, ew[k-1]); end
      checks++;
      if (obs_busy !== eb[k-1]) begin errors++; $display("FAIL stall_busy c%0d: got %b, required %b", k, obs_busy, eb[k-1]); end
      checks++;
      if (obs_owner !== ((k >= 2) ? 2'd1 : 2'd0)) begin
        errors++; $display("FAIL stall_owner c%0d: got %0d, required %0d", k, obs_owner, (k >= 2) ? 1 : 0);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL stall_done: pending=%0d, required 0", exp_q.size()); end
    bus.full = 1'b0;
    chk_exp  = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_drop_full();
    logic [10:0] ew = 11'b00100100010;
    logic [10:0] eb = 11'b01101101110;
    src_q[0].push_back(8'h01); src_q[0].push_back(8'h02);
    src_q[3].push_back(8'h31);
    do_reset();
    exp_q.push_back({2'd0, 8'h01}); exp_q.push_back({2'd3, 8'h31}); exp_q.push_back({2'd0, 8'h02});
    chk_exp = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      bus.full     = (k == 3 || k == 4);
      drop_mask[0] = (k == 4);
      drive_reqs();
      tick();
      checks++;
      if (obs_wen !== ew[k-1]) begin errors++; $display("FAIL drop_wen c%0d: got %b, required %b", k, obs_wen, ew[k-1]); end
      checks++;
      if (obs_busy !== eb[k-1]) begin errors++; $display("FAIL drop_busy c%0d: got %b, required %b", k, obs_busy, eb[k-1]); end
      checks++;
      if (obs_owner !== ((k >= 6 && k <= 8) ? 2'd3 : 2'd0)) begin
        errors++; $display("FAIL drop_owner c%0d: got %0d, required %0d", k, obs_owner, (k >= 6 && k <= 8) ? 3 : 0);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL drop_done: pending=%0d, required 0", exp_q.size()); end
    chk_exp = 1'b0;
    exp_q.delete();
    flush();
  endtask

  task automatic test_reset_mid();
    logic [5:0] ew = 6'b101110;
    logic [5:0] eo [6] = '{2'd0, 2'd3, 2'd3, 2'd3, 2'd0, 2'd0};
    for (int i = 0; i < 12; i++) src_q[3].push_back(8'hC0 + 8'(i));
    do_reset();
    for (int i = 0; i < 3; i++) exp_q.push_back({2'd3, 8'hC0 + 8'(i)});
    exp_q.push_back({2'd0, 8'hD0});
    chk_exp = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      if (k == 2) for (int i = 0; i < 3; i++) src_q[i].push_back(8'hD0 + 8'(i));
      rst = (k == 4);
      drive_reqs();
      tick();
      checks++;
      if (obs_wen !== ew[k-1]) begin errors++; $display("FAIL rmid_wen c%0d: got %b, required %b", k, obs_wen, ew[k-1]); end
      checks++;
      if (obs_busy !== ew[k-1]) begin errors++; $display("FAIL rmid_busy c%0d: got %b, required %b", k, obs_busy, ew[k-1]); end
      checks++;
      if (obs_owner !== eo[k-1][1:0]) begin
        errors++; $display("FAIL rmid_owner c%0d: got %0d, required %0d", k, obs_owner, eo[k-1]);
      end
    end
    rst = 1'b0;
    flush();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL rmid_done: pending=%0d, required 0", exp_q.size()); end
    chk_exp = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_mb1();
    wr_t e;
    for (int i = 0; i < NR; i++) bus1.req_word[i*8 +: 8] = 8'h10 + 8'(i);
    bus1.req = 4'b1111;
    do_reset();
    for (int n = 0; n < 8; n++) exp1_q.push_back({2'(n % 4), 8'h10 + 8'(n % 4)});
    for (int k = 1; k <= 16; k++) begin
      tick();
      checks++;
      if (obs1_wen !== (k % 2 == 0)) begin errors++; $display("FAIL mb1_wen c%0d: got %b, required %b", k, obs1_wen, (k % 2 == 0)); end
      checks++;
      if (!$onehot0(obs1_ack)) begin errors++; $display("FAIL mb1_ack c%0d: got %b, required one-hot", k, obs1_ack); end
      if (obs1_wen) begin
        checks++;
        if (exp1_q.size() == 0) begin
          errors++; $display("FAIL mb1_extra c%0d: owner=%0d, required no write", k, obs1_owner);
        end else begin
          e = exp1_q.pop_front();
          if ({obs1_owner, obs1_word} !== e || obs1_ack !== (4'b0001 << e.id)) begin
            errors++; $display("FAIL mb1_grant c%0d: owner=%0d word=%h ack=%b, required owner=%0d word=%h",
                               k, obs1_owner, obs1_word, obs1_ack, e.id, e.w);
          end
        end
      end
    end
    checks++;
    if (exp1_q.size() != 0) begin errors++; $display("FAIL mb1_done: pending=%0d, required 0", exp1_q.size()); end
    bus1.req = 4'b0000;
    tick();
  endtask

  task automatic test_soak();
    int  len;
    int  guard;
    bit  pend;
    do_reset();
    for (int i = 0; i < NR; i++) wait_cnt[i] = 0;
    soak_en = 1'b1;
    for (int n = 0; n < 10000; n++) begin
      for (int i = 0; i < NR; i++) begin
        if (src_q[i].size() == 0 && $urandom_range(7) == 0) begin
          len = $urandom_range(6, 1);
          for (int j = 0; j < len; j++) src_q[i].push_back(8'($urandom));
        end
      end
      bus.full = ($urandom_range(3) == 0);
      drive_reqs();
      tick();
    end
    soak_en  = 1'b0;
    bus.full = 1'b0;
    drive_reqs();
    guard = 0;
    pend  = 1'b1;
    while (pend && guard < 400) begin
      tick();
      guard++;
      pend = bus.busy;
      for (int i = 0; i < NR; i++) if (src_q[i].size() > 0) pend = 1'b1;
    end
    checks++;
    if (pend) begin errors++; $display("FAIL soak_drain: words still pending after %0d cycles, required drained", guard); end
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    chk_exp   = 1'b0;
    soak_en   = 1'b0;
    drop_mask = '0;
    rst       = 1'b1;
    bus.full  = 1'b0;
    bus1.full = 1'b0;
    bus1.req  = '0;
    bus1.req_word = '0;
    drive_reqs();
    test_reset();
    test_single();
    test_full_stall();
    test_drop_full();
    test_reset_mid();
    test_mb1();
    test_soak();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
